// File: rtl/program_loader.sv
// program_loader: streams a program image into instruction memory while holding the CPU in reset.
// Optional LOADER_CHECKSUM_EN: the in_last beat carries a 16-bit sum of the image and is not written.
module program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH = 128,
  parameter int START_ADDRESS = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  output logic                         imem_write_enable,
  output logic [ADDR_WIDTH-1:0]        imem_address,
  output logic [DATA_WIDTH-1:0]        imem_write_data,
  output logic                         cpu_hold,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(DEPTH+1)-1:0]   words_loaded
);
  localparam int WW = $clog2(DEPTH+1);
  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, DONE, ERROR} state_t;
  state_t state, state_n;
  logic last_q, accept, full, chk, bad, err, wr, fin, begin_load;
  logic [ADDR_WIDTH-1:0] ptr;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum;
  assign chk = in_last;
  assign bad = 16'(in_data) != sum;
`else
  assign chk = 1'b0;
  assign bad = 1'b0;
`endif
  // last_q marks the cycle in which the final write is still on the port
  assign in_ready = state == LOAD && !last_q;
  assign accept = in_valid && in_ready;
  assign full = words_loaded == WW'(DEPTH);
  assign err = accept && (chk ? bad : full);
  assign wr = accept && !chk && !full;
  assign fin = accept && in_last && !err;
  assign begin_load = start && (state == IDLE || state == DONE || state == ERROR);
  assign cpu_hold = state != DONE;
  assign done = state == DONE;
  assign error = state == ERROR;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == LOAD) state_n = last_q ? RELEASE : err ? ERROR : LOAD;
    else if (state == RELEASE) state_n = DONE;
    else if (begin_load) state_n = LOAD;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      imem_write_enable <= 1'b0;
      imem_address <= ADDR_WIDTH'(START_ADDRESS);
      imem_write_data <= '0;
      words_loaded <= '0;
      ptr <= ADDR_WIDTH'(START_ADDRESS);
      last_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      imem_write_enable <= wr;
      if (begin_load) begin
        words_loaded <= '0;
        ptr <= ADDR_WIDTH'(START_ADDRESS);
        last_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum <= '0;
`endif
      end
      if (wr) begin
        imem_address <= ptr;
        imem_write_data <= in_data;
        ptr <= ptr + ADDR_WIDTH'(2);
        words_loaded <= words_loaded + WW'(1);
`ifdef LOADER_CHECKSUM_EN
        sum <= sum + 16'(in_data);
`endif
      end
      if (fin) last_q <= 1'b1;
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed image loads, every cycle compared against a transaction-level loader model.
module tb_program_loader;
  localparam int DEPTH = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int P_IDLE = 0, P_LOAD = 1, P_FIN = 2, P_REL = 3, P_DONE = 4, P_ERR = 5;
  logic clock = 0, reset = 0, start = 0, in_valid = 0, in_last = 0;
  logic [15:0] in_data = 0;
  logic in_ready, imem_write_enable, cpu_hold, done, error;
  logic [7:0] imem_address;
  logic [15:0] imem_write_data;
  logic [2:0] words_loaded;
  int checks = 0, errors = 0, cyc = 0;
  int ph = P_IDLE, cnt = 0;
  logic [7:0] mptr = 0;
  logic [15:0] msum = 0;
  typedef struct {int c; logic [7:0] a; logic [15:0] d;} wr_t;
  wr_t q[$];
  logic [7:0] wa[16];
  logic [15:0] wd[16];
  int wn = 0;
  logic [15:0] img[8];

  program_loader #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .imem_write_enable(imem_write_enable),
    .imem_address(imem_address), .imem_write_data(imem_write_data), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // what one rising edge does, given the inputs that were presented to it
  function automatic void model(input logic st, input logic v, input logic [15:0] d, input logic l);
    if (ph == P_REL) ph = P_DONE;
    else if (ph == P_FIN) ph = P_REL;
    else if (ph == P_LOAD) begin
      if (v) begin
        if (CHK && l) ph = (msum == d) ? P_FIN : P_ERR;
        else if (cnt == DEPTH) ph = P_ERR;
        else begin
          q.push_back('{cyc, mptr, d});
          mptr += 8'd2;
          cnt++;
          msum += d;
          if (l) ph = P_FIN;
        end
      end
    end else if (st) begin
      ph = P_LOAD;
      cnt = 0;
      mptr = 0;
      msum = 0;
    end
  endfunction

  initial forever begin
    bit ew;
    @(negedge clock);
    chk("in_ready", in_ready, ph == P_LOAD);
    chk("cpu_hold", cpu_hold, ph != P_DONE);
    chk("done", done, ph == P_DONE);
    chk("error", error, ph == P_ERR);
    chk("words_loaded", words_loaded, cnt);
    while (q.size() > 0 && q[0].c < cyc) void'(q.pop_front());
    ew = q.size() > 0 && q[0].c == cyc;
    chk("imem_write_enable", imem_write_enable, ew);
    if (ew) begin
      chk("imem_address", imem_address, q[0].a);
      chk("imem_write_data", imem_write_data, q[0].d);
      void'(q.pop_front());
    end
    if (imem_write_enable && wn < 16) begin
      wa[wn] = imem_address;
      wd[wn] = imem_write_data;
      wn++;
    end
  end

  task automatic tick(input logic st, input logic v, input logic [15:0] d, input logic l);
    start = st;
    in_valid = v;
    in_data = d;
    in_last = l;
    @(posedge clock);
    #1;
    model(st, v, d, l);
    start = 0;
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 16'h0, 0);
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    tick(0, 1, d, l);
  endtask

  task automatic load(input int n, input bit gap);
    logic [15:0] s;
    s = 0;
    tick(1, 0, 16'h0, 0);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) idle(1);
      send(img[i], !CHK && i == n - 1);
      s += img[i];
    end
    if (CHK) begin
      if (gap) idle(1);
      send(s, 1);
    end
  endtask

  task automatic do_reset(input string t);
    #1 reset = 1;
    ph = P_IDLE;
    cnt = 0;
    q.delete();
    #1;
    chk({t, "_ready"}, in_ready, 0);
    chk({t, "_we"}, imem_write_enable, 0);
    chk({t, "_addr"}, imem_address, 8'h00);
    chk({t, "_data"}, imem_write_data, 16'h0000);
    chk({t, "_hold"}, cpu_hold, 1);
    chk({t, "_done"}, done, 0);
    chk({t, "_error"}, error, 0);
    chk({t, "_words"}, words_loaded, 0);
    @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic chk_img(input string t, input int n);
    chk({t, "_count"}, wn, n);
    for (int i = 0; i < n; i++) begin
      chk({t, "_addr"}, wa[i], 2 * i);
      chk({t, "_data"}, wd[i], img[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    do_reset("rst");
    img = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    wn = 0;
    load(3, 0);
    chk("t1_done_e0", done, 0);
    idle(1);
    chk("t1_done_e1", done, 0);
    chk("t1_ready_e1", in_ready, 0);
    chk("t1_hold_e1", cpu_hold, 1);
    idle(1);
    chk("t1_done", done, 1);
    chk("t1_hold", cpu_hold, 0);
    chk("t1_words", words_loaded, 3);
    chk("t1_count", wn, 3);
    chk("t1_a0", wa[0], 8'h00);
    chk("t1_a1", wa[1], 8'h02);
    chk("t1_a2", wa[2], 8'h04);
    chk("t1_d0", wd[0], 16'h1234);
    chk("t1_d1", wd[1], 16'hABCD);
    chk("t1_d2", wd[2], 16'h0F0F);
    wn = 0;
    load(3, 1);
    idle(2);
    chk("t2_done", done, 1);
    chk_img("t2", 3);
    img = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0, 16'h0, 16'h0};
    wn = 0;
    load(5, 0);
    idle(2);
    chk("t3_error", error, 1);
    chk("t3_hold", cpu_hold, 1);
    chk("t3_done", done, 0);
    chk("t3_words", words_loaded, 4);
    chk_img("t3", 4);
`ifdef LOADER_CHECKSUM_EN
    img = '{16'h0001, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    wn = 0;
    load(2, 0);
    idle(2);
    chk("t4_done", done, 1);
    chk_img("t4", 2);
    wn = 0;
    tick(1, 0, 16'h0, 0);
    send(16'h0001, 0);
    send(16'hFFFF, 0);
    send(16'h0001, 1);
    idle(2);
    chk("t4_bad_error", error, 1);
    chk("t4_bad_done", done, 0);
    chk("t4_bad_count", wn, 2);
`else
    wn = 0;
    tick(1, 0, 16'h0, 0);
    send(16'h7777, 1);
    idle(2);
    chk("t4_done", done, 1);
    chk("t4_words", words_loaded, 1);
    chk("t4_count", wn, 1);
    chk("t4_a0", wa[0], 8'h00);
    chk("t4_d0", wd[0], 16'h7777);
`endif
    img = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tick(1, 0, 16'h0, 0);
    send(img[0], 0);
    send(img[1], 0);
    chk("t5_we_before", imem_write_enable, 1);
    chk("t5_addr_before", imem_address, 8'h02);
    do_reset("t5");
    wn = 0;
    load(3, 0);
    idle(2);
    chk("t5_done", done, 1);
    chk_img("t5", 3);
    tick(1, 0, 16'h0, 0);
    chk("t6_hold", cpu_hold, 1);
    chk("t6_ready", in_ready, 1);
    chk("t6_words0", words_loaded, 0);
    send(16'h5A5A, !CHK);
    chk("t6_words1", words_loaded, 1);
    if (CHK) send(16'h5A5A, 1);
    idle(2);
    chk("t6_done", done, 1);
    chk("t6_hold_off", cpu_hold, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image into the CPU's instruction memory over a valid/ready word interface while holding the CPU pipeline in reset, then releases the CPU to run. Sits between the bench or host link and the instruction-memory write port. Provides the write side of the same datapath that the fixture and trace logic observe. It is the only writer of instruction memory outside of reset.

## Interface
Parameters:
- DATA_WIDTH, 16, instruction word width
- ADDR_WIDTH, 8, instruction-memory byte-address width
- DEPTH, 128, maximum words loadable (DEPTH*2 ≤ 2^ADDR_WIDTH)
- START_ADDRESS, 0, byte address of first word (even)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
- in_valid  in  1  word present on in_data
- in_ready  out  1  loader accepts a word this cycle
- in_data  in  DATA_WIDTH  program word
- in_last  in  1  marks final beat of image
- imem_write_enable  out  1  instruction-memory write strobe
- imem_address  out  ADDR_WIDTH  byte address of write
- imem_write_data  out  DATA_WIDTH  word to write
- cpu_hold  out  1  active-high; CPU kept in reset while 1
- done  out  1  level; image loaded successfully
- error  out  1  level; overflow or checksum failure
- words_loaded  out  $clog2(DEPTH+1)  words written this load

## Operation
- States: IDLE, LOAD, RELEASE, DONE, ERROR.
- Reset (async, any state): state=IDLE; in_ready=0, imem_write_enable=0, imem_address=START_ADDRESS, imem_write_data=0, cpu_hold=1, done=0, error=0, words_loaded=0.
- IDLE: in_ready=0, cpu_hold=1. On start → LOAD; clear words_loaded, done, error; address pointer = START_ADDRESS.
- LOAD: in_ready=1. A beat is accepted when in_valid & in_ready at a rising edge.
  - Accepted data beat with words_loaded < DEPTH: register write (address = pointer, data = in_data), pointer += 2, words_loaded += 1.
  - Accepted data beat with words_loaded == DEPTH: no write → ERROR.
  - Accepted beat with in_last=1: after it is processed, → RELEASE.
  - start during LOAD: ignored.
- RELEASE: one cycle; in_ready=0, cpu_hold still 1; final write has completed. → DONE.
- DONE: done=1, cpu_hold=0, in_ready=0. On start → LOAD with cpu_hold re-asserted on the next cycle.
- ERROR: error=1, cpu_hold=1, in_ready=0. Only start or reset exits; start → LOAD.
- Pointer arithmetic: wraps modulo 2^ADDR_WIDTH. This is unreachable under the DEPTH constraint.
- An in_last beat with no preceding data beats is legal. It writes one word without checksum, or zero words with checksum.

## Timing
- Write latency: beat accepted at edge N → imem_write_enable=1 with address/data for exactly the cycle after edge N, deasserted after edge N+1 unless another beat was accepted at N+1.
- Back-to-back: one word per cycle sustained; in_ready stays 1 throughout LOAD.
- Last beat accepted at edge N: final write cycle is N→N+1, RELEASE occupies N+1→N+2, done=1 and cpu_hold=0 from edge N+2.
- start → in_ready=1 from the next edge.
- Reset mid-load aborts immediately. Partially written memory is not cleared, and cpu_hold=1.

## Configuration
- LOADER_CHECKSUM_EN defined: the in_last beat is a checksum and is not written. The checksum is the 16-bit sum, modulo 2^16, of all accepted data words. Mismatch → ERROR instead of RELEASE, with no write for that beat. An overflow beat still → ERROR first.
- Undefined: the in_last beat is an ordinary data word, written as above. No checksum logic is present.

## Test plan
- Reset then start; stream 0x1234, 0xABCD, 0x0F0F (last on third), no stalls → writes at 0x00, 0x02, 0x04 on consecutive cycles; done=1, cpu_hold=0 two edges after last accept; words_loaded=3.
- Same stream with in_valid deasserted every other cycle → identical writes, no spurious imem_write_enable in gap cycles.
- DEPTH=4; stream 5 words with last on fifth → 4 writes; 5th beat no write; error=1, cpu_hold=1, done=0.
- LOADER_CHECKSUM_EN: data 0x0001, 0xFFFF, checksum 0x0000 → done=1, 2 writes. Repeat with checksum 0x0001 → error=1.
- Assert reset during the 2nd word of a load → all outputs at reset values the same cycle. A subsequent start and full load completes normally from START_ADDRESS.
- From DONE, pulse start and load 1 word → cpu_hold=1 again during LOAD, words_loaded restarts at 0 then 1.
